// File: rtl/m68k_req_gen.sv
// -----------------------------------------------------------------------------
// m68k_req_gen
//
// Front end that turns 68040 synchronous bus transfers into requests for
// req_wb_bridge. One CPU transfer (long, word, byte or 16-byte line) becomes
// one request. Write beats are posted straight into the bridge write FIFO;
// read beats are popped from the bridge read FIFO and handed to the CPU.
// Every beat is terminated with TA, or the whole transfer with TEA.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : read beats that never arrive time out after TIMEOUT_CYCLES
//               idle cycles. TEA is raised and the late words are drained
//               from the read FIFO without TA.
//   undefined : RDATA waits forever; no timeout or drain counters exist.
//
// Ports
//   clk_i, rst_i             clock (also the CPU bus clock), sync active-high reset
//   cpu_ts_n .. cpu_data_i   68040 bus inputs (TS, address, R/W, SIZ, TT, write data)
//   cpu_data_o, cpu_data_oe  read data and its drive enable
//   cpu_ta_n, cpu_tea_n      beat / error termination
//   req_*                    bridge request port (req_ready is the only input)
//   write_valid, write_data  bridge write FIFO push
//   read_valid, read_data,
//   read_ack                 bridge read FIFO pop
// -----------------------------------------------------------------------------
module m68k_req_gen #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_ts_n,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_siz,
  input  logic [1:0]  cpu_tt,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_data_oe,
  output logic        cpu_ta_n,
  output logic        cpu_tea_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  output logic [2:0]  req_len,
  output logic [3:0]  req_mask,
  output logic        req_we,
  output logic        write_valid,
  output logic [31:0] write_data,
  input  logic        read_valid,
  input  logic [31:0] read_data,
  output logic        read_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WDATA,
    S_RDATA,
    S_ERR
  } state_t;

  state_t      state;
  logic        rd_q;       // captured cpu_rw
  logic [2:0]  beat_cnt;   // beats still owed to the CPU

  logic [3:0]  mask_nxt;
  logic [2:0]  len_nxt;
  logic        rd_beat;    // a read beat completes this cycle
  logic        req_block;  // read request held back behind a pending drain
  logic        drain_pop;  // late word popped with no CPU termination
  logic        tmo_hit;    // read beat wait limit reached this cycle

  // ---------------------------------------------------------------------------
  // Request field decode from the bus at TS. Lanes are big-endian: mask bit 3
  // is data[31:24], i.e. the byte at address offset 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_nxt = 4'b1111;
    unique case (cpu_siz)
      2'b01:   mask_nxt = 4'b1000 >> cpu_addr[1:0];
      2'b10:   mask_nxt = cpu_addr[1] ? 4'b0011 : 4'b1100;
      default: mask_nxt = 4'b1111;
    endcase
  end

  assign len_nxt = (cpu_siz == 2'b11) ? 3'd4 : 3'd1;

  // ---------------------------------------------------------------------------
  // Optional read timeout and drain
  // ---------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic [3:0]    drain_cnt;

  // The drain only ever runs outside RDATA: a new read is held in REQ until
  // the drain is empty, so both can never pop the FIFO in the same cycle.
  assign req_block = rd_q && (drain_cnt != 4'd0);
  assign drain_pop = (drain_cnt != 4'd0) && read_valid && (state != S_RDATA);
  assign tmo_hit   = (state == S_RDATA) && !read_valid &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == S_RDATA) && !read_valid && !tmo_hit)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;

      // Words the CPU abandoned will still land in the read FIFO later.
      if (tmo_hit)
        drain_cnt <= drain_cnt + {1'b0, beat_cnt};
      else if (drain_pop)
        drain_cnt <= drain_cnt - 4'd1;
    end
  end
`else
  assign req_block = 1'b0;
  assign drain_pop = 1'b0;
  assign tmo_hit   = 1'b0;

  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // ---------------------------------------------------------------------------
  // Output decode. req_valid must never rise while req_ready is low, since the
  // bridge request FIFO writes on req_valid alone.
  // ---------------------------------------------------------------------------
  assign rd_beat     = (state == S_RDATA) && read_valid;
  assign req_valid   = (state == S_REQ) && req_ready && !req_block;
  assign write_valid = (state == S_WDATA);
  assign write_data  = cpu_data_i;
  assign read_ack    = rd_beat || drain_pop;
  assign cpu_data_oe = rd_beat;
  assign cpu_data_o  = rd_beat ? read_data : 32'd0;
  assign cpu_ta_n    = !(write_valid || rd_beat);
  assign cpu_tea_n   = !((state == S_ERR) || tmo_hit);

  // ---------------------------------------------------------------------------
  // Transfer FSM. TS outside IDLE is ignored: the 68040 never starts a new
  // transfer before the current one is terminated.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      rd_q     <= 1'b0;
      req_addr <= '0;
      req_len  <= '0;
      req_mask <= '0;
      req_we   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!cpu_ts_n) begin
            // Line transfers keep addr[3:2]; the bridge does the
            // critical-word-first wrap.
            req_addr <= cpu_addr;
            req_len  <= len_nxt;
            req_mask <= mask_nxt;
            req_we   <= !cpu_rw;
            rd_q     <= cpu_rw;
            beat_cnt <= len_nxt;
            state    <= (cpu_tt != 2'b00) ? S_ERR : S_REQ;
          end
        end

        S_REQ: begin
          if (req_valid)
            state <= rd_q ? S_RDATA : S_WDATA;
        end

        // Write beats are posted one per cycle; the bridge write FIFO is
        // sized so that it can always take a full line.
        S_WDATA: begin
          beat_cnt <= beat_cnt - 3'd1;
          if (beat_cnt <= 3'd1)
            state <= S_IDLE;
        end

        S_RDATA: begin
          if (rd_beat) begin
            beat_cnt <= beat_cnt - 3'd1;
            if (beat_cnt <= 3'd1)
              state <= S_IDLE;
          end else if (tmo_hit) begin
            beat_cnt <= '0;
            state    <= S_IDLE;
          end
        end

        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
